// File: rtl/alu_control_mext_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_pkg
// Brief    : Op codes, ALU_Op classes, funct7 values and FSM states shared by
//            the ALU control unit and its decoder.
// Revision : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

    localparam logic [4:0] c_op_add    = 5'd0;
    localparam logic [4:0] c_op_sub    = 5'd1;
    localparam logic [4:0] c_op_sll    = 5'd2;
    localparam logic [4:0] c_op_slt    = 5'd3;
    localparam logic [4:0] c_op_sltu   = 5'd4;
    localparam logic [4:0] c_op_xor    = 5'd5;
    localparam logic [4:0] c_op_srl    = 5'd6;
    localparam logic [4:0] c_op_sra    = 5'd7;
    localparam logic [4:0] c_op_or     = 5'd8;
    localparam logic [4:0] c_op_and    = 5'd9;
    localparam logic [4:0] c_op_pass_b = 5'd10;
    localparam logic [4:0] c_op_mul    = 5'd16;
    localparam logic [4:0] c_op_remu   = 5'd23;

    localparam logic [2:0] c_cls_rtype  = 3'b000;
    localparam logic [2:0] c_cls_iarith = 3'b001;
    localparam logic [2:0] c_cls_lui    = 3'b010;
    localparam logic [2:0] c_cls_branch = 3'b011;
    localparam logic [2:0] c_cls_ldst   = 3'b100;
    localparam logic [2:0] c_cls_auipc  = 3'b101;
    localparam logic [2:0] c_cls_jal    = 3'b110;
    localparam logic [2:0] c_cls_rsvd   = 3'b111;

    localparam logic [6:0] c_f7_base = 7'b0000000;
    localparam logic [6:0] c_f7_alt  = 7'b0100000;
    localparam logic [6:0] c_f7_mext = 7'b0000001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // funct3 mapping shared by R-type funct7=0000000 and most I-arith ops
    function automatic logic [4:0] base_op(input logic [2:0] funct3);
        case (funct3)
            3'b000:  base_op = c_op_add;
            3'b001:  base_op = c_op_sll;
            3'b010:  base_op = c_op_slt;
            3'b011:  base_op = c_op_sltu;
            3'b100:  base_op = c_op_xor;
            3'b101:  base_op = c_op_srl;
            3'b110:  base_op = c_op_or;
            default: base_op = c_op_and;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_control_mext_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_control_mext_if
// Brief    : Instruction-field inputs and ALU/MDU control outputs of the
//            ALU control unit.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_control_mext_if #(
    parameter int OP_W = 5
);
    logic            valid_i;
    logic [6:0]      funct7_i;
    logic [2:0]      ALU_Op_i;
    logic [2:0]      funct3_i;
    logic            kill_i;
    logic [OP_W-1:0] ALU_Operation_o;
    logic            muldiv_sel_o;
    logic            muldiv_start_o;
    logic            muldiv_done_o;
    logic            stall_o;
    logic            illegal_o;

    modport master (
        output valid_i, funct7_i, ALU_Op_i, funct3_i, kill_i,
        input  ALU_Operation_o, muldiv_sel_o, muldiv_start_o,
               muldiv_done_o, stall_o, illegal_o
    );

    modport slave (
        input  valid_i, funct7_i, ALU_Op_i, funct3_i, kill_i,
        output ALU_Operation_o, muldiv_sel_o, muldiv_start_o,
               muldiv_done_o, stall_o, illegal_o
    );
endinterface
`default_nettype wire

// File: rtl/alu_control_mext_decode.sv
`default_nettype none
// ============================================================================
// Module   : alu_decode
// Brief    : Combinational ALU_Op/funct3/funct7 decode into op code plus
//            mul/div and illegal flags.
// Revision : 1.0 - initial release
// ============================================================================
module alu_decode
    import alu_ctrl_pkg::*;
(
    input  wire logic [2:0] alu_op,
    input  wire logic [2:0] funct3,
    input  wire logic [6:0] funct7,
    output logic      [4:0] op_code,
    output logic            is_muldiv,
    output logic            is_div,
    output logic            illegal
);

    // Illegal paths leave op_code at ADD
    always_comb begin
        op_code   = c_op_add;
        is_muldiv = 1'b0;
        is_div    = 1'b0;
        illegal   = 1'b0;
        case (alu_op)
            c_cls_rtype: begin
                case (funct7)
                    c_f7_base: op_code = base_op(funct3);
                    c_f7_alt: begin
                        if (funct3 == 3'b000)      op_code = c_op_sub;
                        else if (funct3 == 3'b101) op_code = c_op_sra;
                        else                       illegal = 1'b1;
                    end
                    c_f7_mext: begin
                        op_code   = c_op_mul | {2'b00, funct3};
                        is_muldiv = 1'b1;
                        is_div    = funct3[2];
                    end
                    default: illegal = 1'b1;
                endcase
            end
            c_cls_iarith: begin
                case (funct3)
                    3'b001: begin
                        if (funct7 == c_f7_base) op_code = c_op_sll;
                        else                     illegal = 1'b1;
                    end
                    3'b101: begin
                        if (funct7 == c_f7_base)     op_code = c_op_srl;
                        else if (funct7 == c_f7_alt) op_code = c_op_sra;
                        else                         illegal = 1'b1;
                    end
                    default: op_code = base_op(funct3);
                endcase
            end
            c_cls_lui: op_code = c_op_pass_b;
            c_cls_branch: begin
                case (funct3[2:1])
                    2'b00:   op_code = c_op_sub;
                    2'b10:   op_code = c_op_slt;
                    2'b11:   op_code = c_op_sltu;
                    default: illegal = 1'b1;
                endcase
            end
            c_cls_ldst, c_cls_auipc, c_cls_jal: op_code = c_op_add;
            default: illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_control_mext.sv
`default_nettype none
// ============================================================================
// Module   : alu_control_mext
// Brief    : RV32IM ALU control with a sequencer that stalls the datapath for
//            multi-cycle MUL/DIV and pulses start/done to the MDU.
// Revision : 1.0 - initial release
// ============================================================================
module alu_control_mext
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W    = 5,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 33,
    parameter int CNT_W   = 6
) (
    input  wire logic          clk,
    input  wire logic          reset,
    alu_control_mext_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_mul_cnt = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] c_div_cnt = CNT_W'(DIV_LAT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [4:0]       r_op;
    logic [CNT_W-1:0] r_cnt;

    logic [4:0]       w_dec_op;
    logic             w_is_muldiv;
    logic             w_is_div;
    logic             w_dec_illegal;
    logic             w_load;
    logic [CNT_W-1:0] w_lat_cnt;
    logic [4:0]       w_op;

    alu_decode u_decode (
        .alu_op    (bus.ALU_Op_i),
        .funct3    (bus.funct3_i),
        .funct7    (bus.funct7_i),
        .op_code   (w_dec_op),
        .is_muldiv (w_is_muldiv),
        .is_div    (w_is_div),
        .illegal   (w_dec_illegal)
    );

    assign w_lat_cnt           = w_is_div ? c_div_cnt : c_mul_cnt;
    assign bus.ALU_Operation_o = OP_W'(w_op);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= c_op_add;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_op  <= w_dec_op;
                r_cnt <= w_lat_cnt;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // Reset gates the IDLE outputs so a still-presented mul/div cannot raise
    // stall while reset is held
    always_comb begin
        w_state_nxt        = r_state;
        w_load             = 1'b0;
        w_op               = w_dec_op;
        bus.stall_o        = 1'b0;
        bus.muldiv_start_o = 1'b0;
        bus.muldiv_done_o  = 1'b0;
        bus.muldiv_sel_o   = 1'b0;
        bus.illegal_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.illegal_o = bus.valid_i && w_dec_illegal && !reset;
                if (bus.valid_i && w_is_muldiv && !bus.kill_i && !reset) begin
                    w_load             = 1'b1;
                    bus.stall_o        = 1'b1;
                    bus.muldiv_start_o = 1'b1;
                    bus.muldiv_sel_o   = 1'b1;
                    w_state_nxt        = (w_lat_cnt != '0) ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                w_op             = r_op;
                bus.stall_o      = 1'b1;
                bus.muldiv_sel_o = 1'b1;
                if (bus.kill_i)                  w_state_nxt = S_IDLE;
                else if (r_cnt <= CNT_W'(1))     w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_op              = r_op;
                bus.muldiv_sel_o  = 1'b1;
                bus.muldiv_done_o = !bus.kill_i;
                w_state_nxt       = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_control_mext.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_control_mext
// Brief    : Directed self-checking bench for alu_control_mext.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_control_mext;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    int   n_stall;
    int   n_done;
    int   done_at;
    int   op_bad;

    alu_control_mext_if #(.OP_W(5)) bus ();

    alu_control_mext #(
        .OP_W    (5),
        .MUL_LAT (2),
        .DIV_LAT (33),
        .CNT_W   (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] cls, input logic [6:0] f7,
                         input logic [2:0] f3, input logic k);
        bus.valid_i  = v;
        bus.ALU_Op_i = cls;
        bus.funct7_i = f7;
        bus.funct3_i = f3;
        bus.kill_i   = k;
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_stall"}, bus.stall_o, 1'b0);
        chk({tag, "_start"}, bus.muldiv_start_o, 1'b0);
        chk({tag, "_done"},  bus.muldiv_done_o, 1'b0);
        chk({tag, "_sel"},   bus.muldiv_sel_o, 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        drive(1'b0, 3'b000, 7'h00, 3'b000, 1'b0);
        #1;
        chk_idle("reset");
        chk("reset_illegal", bus.illegal_o, 1'b0);
        chk("reset_op", bus.ALU_Operation_o, 5'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Single-cycle decode
        drive(1'b1, 3'b000, 7'h20, 3'b101, 1'b0);
        chk("r_sra_op", bus.ALU_Operation_o, 5'd7);
        chk("r_sra_stall", bus.stall_o, 1'b0);
        drive(1'b1, 3'b000, 7'h00, 3'b111, 1'b0);
        chk("r_and_op", bus.ALU_Operation_o, 5'd9);
        chk("r_and_ill", bus.illegal_o, 1'b0);
        drive(1'b1, 3'b001, 7'h20, 3'b101, 1'b0);
        chk("i_srai_op", bus.ALU_Operation_o, 5'd7);
        drive(1'b1, 3'b001, 7'h55, 3'b110, 1'b0);
        chk("i_ori_op", bus.ALU_Operation_o, 5'd8);
        drive(1'b1, 3'b001, 7'h20, 3'b001, 1'b0);
        chk("i_slli_bad_ill", bus.illegal_o, 1'b1);
        chk("i_slli_bad_op", bus.ALU_Operation_o, 5'd0);
        drive(1'b1, 3'b010, 7'h00, 3'b000, 1'b0);
        chk("lui_op", bus.ALU_Operation_o, 5'd10);
        drive(1'b1, 3'b011, 7'h00, 3'b111, 1'b0);
        chk("br_sltu_op", bus.ALU_Operation_o, 5'd4);
        drive(1'b1, 3'b011, 7'h00, 3'b101, 1'b0);
        chk("br_slt_op", bus.ALU_Operation_o, 5'd3);
        drive(1'b1, 3'b011, 7'h00, 3'b011, 1'b0);
        chk("br_01x_ill", bus.illegal_o, 1'b1);
        drive(1'b1, 3'b110, 7'h00, 3'b000, 1'b0);
        chk("jal_op", bus.ALU_Operation_o, 5'd0);
        chk("jal_ill", bus.illegal_o, 1'b0);

        // Illegal encodings
        drive(1'b1, 3'b000, 7'h20, 3'b001, 1'b0);
        chk("r_ill_ill", bus.illegal_o, 1'b1);
        chk("r_ill_op", bus.ALU_Operation_o, 5'd0);
        chk_idle("r_ill");
        drive(1'b1, 3'b111, 7'h00, 3'b000, 1'b0);
        chk("rsvd_ill", bus.illegal_o, 1'b1);
        drive(1'b0, 3'b111, 7'h00, 3'b000, 1'b0);
        chk("rsvd_novalid_ill", bus.illegal_o, 1'b0);
        drive(1'b0, 3'b000, 7'h01, 3'b000, 1'b0);
        chk_idle("mul_novalid");
        chk("mul_novalid_op", bus.ALU_Operation_o, 5'd16);

        // kill_i in IDLE blocks a start
        drive(1'b1, 3'b000, 7'h01, 3'b000, 1'b1);
        chk_idle("kill_idle");
        tick();
        drive(1'b0, 3'b000, 7'h00, 3'b000, 1'b0);
        chk_idle("kill_idle_next");

        // MUL, MUL_LAT = 2
        drive(1'b1, 3'b000, 7'h01, 3'b000, 1'b0);
        chk("mul_c0_start", bus.muldiv_start_o, 1'b1);
        chk("mul_c0_stall", bus.stall_o, 1'b1);
        chk("mul_c0_sel", bus.muldiv_sel_o, 1'b1);
        chk("mul_c0_op", bus.ALU_Operation_o, 5'd16);
        tick();
        chk("mul_c1_start", bus.muldiv_start_o, 1'b0);
        chk("mul_c1_stall", bus.stall_o, 1'b1);
        chk("mul_c1_done", bus.muldiv_done_o, 1'b0);
        chk("mul_c1_op", bus.ALU_Operation_o, 5'd16);
        tick();
        drive(1'b0, 3'b000, 7'h00, 3'b000, 1'b0);
        chk("mul_c2_done", bus.muldiv_done_o, 1'b1);
        chk("mul_c2_stall", bus.stall_o, 1'b0);
        chk("mul_c2_sel", bus.muldiv_sel_o, 1'b1);
        chk("mul_c2_op", bus.ALU_Operation_o, 5'd16);
        tick();
        chk_idle("mul_c3");

        // DIVU, DIV_LAT = 33, inputs scrambled mid-BUSY
        drive(1'b1, 3'b000, 7'h01, 3'b101, 1'b0);
        chk("divu_c0_start", bus.muldiv_start_o, 1'b1);
        chk("divu_c0_op", bus.ALU_Operation_o, 5'd21);
        n_stall = 0;
        n_done  = 0;
        done_at = -1;
        op_bad  = 0;
        for (int i = 0; i < 45; i++) begin
            if (i == 3) drive(1'b1, 3'b111, 7'h7f, 3'b000, 1'b0);
            if (bus.stall_o) n_stall++;
            if (bus.muldiv_done_o) begin
                n_done++;
                done_at = i;
            end
            if ((bus.stall_o || bus.muldiv_done_o) && bus.ALU_Operation_o !== 5'd21) op_bad++;
            tick();
        end
        chk("divu_stall_cycles", n_stall, 33);
        chk("divu_done_pulses", n_done, 1);
        chk("divu_done_cycle", done_at, 33);
        chk("divu_op_held", op_bad, 0);
        chk("divu_after_ill", bus.illegal_o, 1'b1);
        chk_idle("divu_after");

        // kill_i in BUSY cycle 5 of a DIV
        drive(1'b1, 3'b000, 7'h01, 3'b100, 1'b0);
        chk("kill_c0_start", bus.muldiv_start_o, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        drive(1'b0, 3'b000, 7'h00, 3'b000, 1'b1);
        chk("kill_c5_stall", bus.stall_o, 1'b1);
        tick();
        drive(1'b0, 3'b000, 7'h00, 3'b000, 1'b0);
        chk_idle("kill_c6");
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.muldiv_done_o || bus.stall_o) n_done++;
            tick();
        end
        chk("kill_no_done", n_done, 0);
        drive(1'b1, 3'b000, 7'h00, 3'b000, 1'b0);
        chk("kill_add_op", bus.ALU_Operation_o, 5'd0);
        chk("kill_add_stall", bus.stall_o, 1'b0);
        drive(1'b1, 3'b000, 7'h20, 3'b000, 1'b0);
        chk("kill_sub_op", bus.ALU_Operation_o, 5'd1);

        // Asynchronous reset mid-DIV
        drive(1'b1, 3'b000, 7'h01, 3'b100, 1'b0);
        chk("rst_div_start", bus.muldiv_start_o, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        chk("rst_div_busy", bus.stall_o, 1'b1);
        reset = 1'b1;
        #1;
        chk_idle("rst_mid");
        chk("rst_mid_ill", bus.illegal_o, 1'b0);
        drive(1'b0, 3'b000, 7'h00, 3'b000, 1'b0);
        chk("rst_mid_op", bus.ALU_Operation_o, 5'd0);
        tick();
        reset = 1'b0;
        tick();
        drive(1'b1, 3'b000, 7'h01, 3'b110, 1'b0);
        chk("rem_c0_start", bus.muldiv_start_o, 1'b1);
        chk("rem_c0_op", bus.ALU_Operation_o, 5'd22);
        tick();
        drive(1'b0, 3'b000, 7'h00, 3'b000, 1'b0);
        n_stall = 1;
        n_done  = 0;
        for (int i = 1; i < 40; i++) begin
            if (bus.stall_o) n_stall++;
            if (bus.muldiv_done_o) n_done++;
            tick();
        end
        chk("rem_stall_cycles", n_stall, 33);
        chk("rem_done_pulses", n_done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_control_mext.md
Name: alu_control_mext

Overview:
- Successor ALU control unit for the RISC-V core, generalised to full RV32I ALU decode plus the M extension.
- Decodes ALU_Op/funct3/funct7 into a parametrised-width ALU operation code, same as before.
- Adds a sequencing FSM for multi-cycle MUL/DIV. It issues start to the mul/div unit, stalls the single-cycle datapath for a configurable latency and signals completion.
- Sits between the main control unit and the ALU/MDU, driving the PC-hold (stall) path.

Parameters:
- OP_W, 5, width of ALU_Operation_o; must be >= 5.
- MUL_LAT, 2, total stall cycles for MUL/MULH/MULHSU/MULHU; must be >= 1.
- DIV_LAT, 33, total stall cycles for DIV/DIVU/REM/REMU; must be >= 1.
- CNT_W, 6, latency counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- valid_i  in  1  instruction fields are valid this cycle.
- funct7_i  in  7  instruction[31:25].
- ALU_Op_i  in  3  class from the main control unit.
- funct3_i  in  3  instruction[14:12].
- kill_i  in  1  abort any in-flight mul/div; return to IDLE.
- ALU_Operation_o  out  OP_W  operation code to ALU/MDU.
- muldiv_sel_o  out  1  writeback mux selects the MDU result.
- muldiv_start_o  out  1  one-cycle start pulse to the MDU.
- muldiv_done_o  out  1  one-cycle pulse; MDU result is valid for writeback.
- stall_o  out  1  hold PC and suppress register-file write.
- illegal_o  out  1  unsupported encoding while valid_i is high.

Behaviour:
- ALU_Op classes:
  - 000 R-type.
  - 001 I-arith.
  - 010 LUI.
  - 011 branch.
  - 100 load/store.
  - 101 AUIPC.
  - 110 JAL/JALR.
  - 111 reserved.
- Op codes:
  - ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASS_B=10.
  - MUL..REMU = 16+funct3 (16..23).
- R-type decode:
  - funct7 0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7 0100000: funct3 000 SUB, 101 SRA; any other funct3 is illegal.
  - funct7 0000001: M-extension op, code 16+funct3.
  - Any other funct7 is illegal.
- I-arith decode:
  - Same mapping as R-type funct7 0000000 for funct3 000/010/011/100/110/111, funct7 ignored.
  - 001 SLLI requires funct7=0000000.
  - 101: funct7 0000000 gives SRLI, 0100000 gives SRAI; anything else is illegal.
- Other classes:
  - LUI gives PASS_B.
  - Branch: funct3 00x gives SUB, 10x gives SLT, 11x gives SLTU, 01x is illegal.
  - Load/store, AUIPC and JAL all give ADD.
  - 111 is illegal.
- Illegal encodings: ALU_Operation_o=ADD, illegal_o=valid_i, no mul/div started.
- Decode is combinational; single-cycle ops have zero added latency and stall_o=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If valid_i and the decoded op is in 16..23, assert combinationally stall_o=1, muldiv_start_o=1, muldiv_sel_o=1.
  - In that case, latch the op code and load cnt = LAT-1 (LAT = MUL_LAT for codes 16-19, DIV_LAT for 20-23).
  - Next state is BUSY if LAT>1, else DONE.
- BUSY:
  - Outputs: stall_o=1, muldiv_sel_o=1, ALU_Operation_o = latched op; inputs are ignored.
  - Each cycle cnt decrements; at cnt==1 the next state is DONE.
- DONE:
  - Outputs: stall_o=0, muldiv_done_o=1, muldiv_sel_o=1, ALU_Operation_o = latched op.
  - Next state is IDLE unconditionally, so the same still-presented instruction is never restarted.
- Latency: stall_o is high for exactly LAT consecutive cycles, followed by one DONE cycle.
- kill_i:
  - In BUSY or DONE: next state IDLE, no muldiv_done_o pulse.
  - In IDLE: suppresses muldiv_start_o and stall_o for that cycle.
  - kill_i has priority over all other transitions.
- Reset outputs:
  - stall_o, muldiv_start_o, muldiv_done_o, muldiv_sel_o and illegal_o are 0.
  - State is IDLE, latched op = ADD, cnt = 0.
  - ALU_Operation_o follows combinational decode (ADD when inputs are 0).
- Reset mid-operation: immediate return to IDLE, stall_o drops asynchronously, no done pulse.
- valid_i low in IDLE: decode is still driven, but stall_o, start and illegal_o are all 0.

Decomposition:
- Package alu_ctrl_pkg holds:
  - ALU op code localparams (ADD..REMU).
  - ALU_Op class encodings.
  - funct7 constants (0000000, 0100000, 0000001).
  - FSM state encodings.
- Sub-module alu_decode: purely combinational field decode producing op code, is_muldiv, is_div and illegal. Instantiated once, so the FSM wrapper stays small.

Test Plan:
- R-type sweep: funct7=0100000, funct3=101, valid_i=1 -> ALU_Operation_o=7 (SRA), stall_o=0. funct7=0000000, funct3=111 -> 9 (AND).
- MUL with MUL_LAT=2: R-type, funct7=0000001, funct3=000 -> start pulse at cycle 0, stall_o high for cycles 0-1, muldiv_done_o at cycle 2, ALU_Operation_o=16 throughout, back in IDLE at cycle 3.
- DIVU with DIV_LAT=33: funct3=101 -> stall_o high for exactly 33 cycles, one done pulse, op=21. Inputs changed mid-BUSY have no effect.
- Illegal: R-type with funct7=0100000, funct3=001, and ALU_Op=111 -> illegal_o=1, op=0, stall_o=0, no start.
- kill_i asserted in BUSY cycle 5 of a DIV -> next cycle IDLE, stall_o=0, no done pulse. A following ADD decodes normally.
- reset asserted asynchronously mid-DIV -> all outputs 0 and state IDLE before the next clock edge. After release, REM starts cleanly with op=22.
